// File: rtl/matrix_mul_pkg.sv
// Shared definitions for the matrix multiplier datapath: block-MAC state encoding,
// latency and default operand width.
package matrix_mul_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Capture edge to c_* update; the control unit's MAC delay must be >= this.
    localparam int unsigned MAC_LATENCY = 10;
    localparam int unsigned DATA_W      = 32;

endpackage

// File: rtl/mac_step_unit.sv
// Registered multiply followed by a registered first-product select; the second
// product of each pair is summed combinationally for the caller to register.
module mac_step_unit #(
    parameter int unsigned data_w = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mul_en_i,
    input  logic              first_i,
    input  logic [data_w-1:0] a_i,
    input  logic [data_w-1:0] b_i,
    output logic [data_w-1:0] sum_o,
    output logic              fin_o
);

    logic [data_w-1:0] prod_q;
    logic [data_w-1:0] acc_q;
    logic              vld_q;
    logic              first_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_q  <= '0;
            acc_q   <= '0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            vld_q <= mul_en_i;
            if (mul_en_i) begin
                prod_q  <= a_i * b_i;
                first_q <= first_i;
            end
            if (vld_q && first_q) begin
                acc_q <= prod_q;
            end
        end
    end

    assign sum_o = acc_q + prod_q;
    assign fin_o = vld_q & ~first_q;

endmodule

// File: rtl/matrix_block_mac.sv
// 2x2 block multiplier C = A*B using one time-shared multiplier over 8 steps;
// fixed 10-cycle latency from operand capture to c_* update.
module matrix_block_mac
    import matrix_mul_pkg::*;
#(
    parameter int unsigned data_w = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_mac,
    input  logic [data_w-1:0] a_11,
    input  logic [data_w-1:0] a_12,
    input  logic [data_w-1:0] a_21,
    input  logic [data_w-1:0] a_22,
    input  logic [data_w-1:0] b_11,
    input  logic [data_w-1:0] b_12,
    input  logic [data_w-1:0] b_21,
    input  logic [data_w-1:0] b_22,
    output logic [data_w-1:0] c_11,
    output logic [data_w-1:0] c_12,
    output logic [data_w-1:0] c_21,
    output logic [data_w-1:0] c_22,
    output logic              done_mac,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [2:0]        s_q, s_d;
    logic              drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_q;
    logic [1:0]        rsel_q;
    logic [data_w-1:0] a_q [4];
    logic [data_w-1:0] b_q [4];
    logic [data_w-1:0] r_q [4];
    logic [data_w-1:0] c_q [4];

    logic              start_edge;
    logic              capture;
    logic              mul_en;
    logic              c_load;
    logic [data_w-1:0] a_sel;
    logic [data_w-1:0] b_sel;
    logic [data_w-1:0] sum;
    logic              fin;

    assign start_edge = start_mac & ~start_q;

    // Step s: i = s[2]+1, j = s[1]+1, k = s[0]+1; arrays are indexed {row, col}.
    assign a_sel = a_q[{s_q[2], s_q[0]}];
    assign b_sel = b_q[{s_q[0], s_q[1]}];

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        drain_d = drain_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        capture = 1'b0;
        mul_en  = 1'b0;
        c_load  = 1'b0;
        if (done_q) begin
            busy_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (start_edge) begin
                    capture = 1'b1;
                    s_d     = 3'd0;
                    drain_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StMul;
                end
            end
            StMul: begin
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = StDone;
                end else begin
                    mul_en = 1'b1;
                    s_d    = s_q + 3'd1;
                    if (s_q == 3'd7) begin
                        drain_d = 1'b1;
                    end
                end
            end
            StDone: begin
                c_load  = 1'b1;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            s_q     <= 3'd0;
            drain_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b1;
            rsel_q  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                r_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_mac;
            if (capture) begin
                a_q[0] <= a_11;
                a_q[1] <= a_12;
                a_q[2] <= a_21;
                a_q[3] <= a_22;
                b_q[0] <= b_11;
                b_q[1] <= b_12;
                b_q[2] <= b_21;
                b_q[3] <= b_22;
            end
            if (mul_en) begin
                rsel_q <= {s_q[2], s_q[1]};
            end
            if (fin) begin
                r_q[rsel_q] <= sum;
            end
            if (c_load) begin
                for (int i = 0; i < 4; i++) begin
                    c_q[i] <= r_q[i];
                end
            end
        end
    end

    mac_step_unit #(
        .data_w (data_w)
    ) u_step (
        .clk_i    (clk),
        .rst_ni   (rst),
        .mul_en_i (mul_en),
        .first_i  (~s_q[0]),
        .a_i      (a_sel),
        .b_i      (b_sel),
        .sum_o    (sum),
        .fin_o    (fin)
    );

    assign c_11     = c_q[0];
    assign c_12     = c_q[1];
    assign c_21     = c_q[2];
    assign c_22     = c_q[3];
    assign done_mac = done_q;
    assign busy     = busy_q;

endmodule

// File: doc/matrix_block_mac.md
# matrix_block_mac

2x2 block multiplier for the matrix multiplier datapath. The control unit presents one 2x2 block of A and one 2x2 block of B and pulses `start_mac`; this block computes C = A·B and returns `c_11..c_22` with `done_mac`. Those four results then go to the accumulator. Internally a single multiplier is time-shared over 8 sequential steps. Latency is fixed at 10 cycles, well inside the control unit's 23-cycle MAC wait.

## Interface
- `data_w`, 32, operand/result width; two's-complement integer
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `start_mac`  in  1  start request; a rising edge is accepted only in IDLE
- `a_11, a_12, a_21, a_22`  in  data_w each  A block, row/column indexed
- `b_11, b_12, b_21, b_22`  in  data_w each  B block
- `c_11, c_12, c_21, c_22`  out  data_w each  result block; held until the next completion
- `done_mac`  out  1  one-cycle pulse when `c_*` are updated
- `busy`  out  1  high from operand capture until `done_mac` deasserts

## Operation
- States: IDLE, MUL, DONE.
- Edge detect:
  - `start_q` registers `start_mac`.
  - edge = `start_mac & ~start_q`.
  - `start_q` resets to 1, so a `start_mac` already high at reset release is not an edge.
- IDLE:
  - On an edge, latch all 8 operands into internal registers, clear step counter `s` (3 bits), go to MUL, set `busy`.
  - Otherwise stay in IDLE.
- MUL, step s = 0..7, with i = s[2]+1, j = s[1]+1, k = s[0]+1:
  - `prod <= a_ik * b_kj`, keeping the low data_w bits.
  - One cycle later, if k = 1: `acc <= prod`. If k = 2: `r_ij <= acc + prod`, wrapping modulo 2^data_w.
  - After s = 7, spend one drain cycle for the final add, then go to DONE.
- DONE:
  - Copy `r_11..r_22` to `c_11..c_22` simultaneously and pulse `done_mac` for one cycle.
  - Next cycle: IDLE, `busy` = 0.
- No queueing. Edges seen while MUL or DONE are discarded. `start_mac` held high for any length produces exactly one computation.
- Operands are captured once, so input changes after the capture edge do not affect the result.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `c_*` = 0, `done_mac` = 0, `busy` = 0, state IDLE, `s` = 0, `start_q` = 1.
  - Internal product, accumulator and result registers = 0.
- Capture edge is E0, where `start_mac` is first sampled high after being low.
  - E1..E8: product registered for steps 0..7.
  - E2..E9: `acc`/`r_ij` updates.
  - E10: `c_*` update; `done_mac` is high during the cycle after E10.
  - `busy` is high from E0 until E11.
- Back-to-back: an edge sampled on E11 or later (state IDLE) is accepted. Minimum start-to-start period is 11 cycles.
- Reset mid-operation: the computation is aborted, no `done_mac` is produced, and `c_*` return to 0.
- `c_*` never change except at the DONE transition or on reset.

## Structure
- Shared package `matrix_mul_pkg`:
  - state encoding (IDLE/MUL/DONE)
  - `MAC_LATENCY` = 10
  - default `data_w` = 32
  - The control unit's MAC delay constant must satisfy delay ≥ `MAC_LATENCY`.
- One sub-module, `mac_step_unit`: a registered multiply plus a registered add/first-product select, parameterized by `data_w`. The FSM, step counter, operand mux and result registers stay in `matrix_block_mac`.

## Test plan
- A = [[1,2],[3,4]], B = identity, one-cycle `start_mac` → C = [[1,2],[3,4]]; `done_mac` pulses exactly 10 edges after capture; `busy` is low afterwards.
- A = [[1,2],[3,4]], B = [[5,6],[7,8]] → C = [[19,22],[43,50]].
- Wrap and sign:
  - a_11 = 0x80000000, b_11 = 2, all other operands 0 → c_11 = 0.
  - All a = 0xFFFFFFFF (−1), all b = 1 → every c = 0xFFFFFFFE (−2).
- `start_mac` held high for 3 cycles, plus an extra pulse at E5 → exactly one `done_mac`. Change the a/b inputs at E1 → result uses the E0 operands.
- Reset mid-operation and at release:
  - Assert `rst` at E4 → `c_*` = 0, no `done_mac`.
  - Hold `start_mac` high across reset release → no computation until `start_mac` goes low then high.
- Back-to-back: start a second computation with B = 2·I at E11 → the first result is held through E20; `c_*` become 2·A at E21, with `done_mac` high in the cycle after E21.
